fsm_101_0110: RTL and testbench



---
 rtl/fsm_101_0110.sv | 42 ++++
 tb/tb_fsm_101_0110.sv | 105 ++++++++++
 2 files changed

// File: rtl/fsm_101_0110.sv
// fsm_101_0110: overlapping Moore detector for the serial patterns 101 and 0110
module fsm_101_0110 (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic y
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S0    = 3'd1,
    S1    = 3'd2,
    S01   = 3'd3,
    S10   = 3'd4,
    S011  = 3'd5,
    M101  = 3'd6,
    M0110 = 3'd7
  } state_t;
  state_t cst;
  function automatic state_t nxt(input state_t s, input logic d);
    case (s)
      IDLE:    nxt = d ? S1   : S0;
      S0:      nxt = d ? S01  : S0;
      S1:      nxt = d ? S1   : S10;
      S01:     nxt = d ? S011 : S10;
      S10:     nxt = d ? M101 : S0;
      S011:    nxt = d ? S1   : M0110;
      M101:    nxt = d ? S011 : S10;
      M0110:   nxt = d ? M101 : S0;
      default: nxt = IDLE;
    endcase
  endfunction
  // advance the suffix tracker and register the match flag with the state it decodes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cst <= IDLE;
      y   <= 1'b0;
    end else begin
      cst <= nxt(cst, din);
      y   <= (nxt(cst, din) == M101) || (nxt(cst, din) == M0110);
    end
  end
endmodule

// File: tb/tb_fsm_101_0110.sv
// tb_fsm_101_0110: directed and random checks against a bit-history reference
module tb_fsm_101_0110;
  logic clk = 1'b0;
  logic reset;
  logic din;
  logic y;
  int errors = 0;
  int checks = 0;
  logic [3:0] hist;
  int nbits;
  logic [15:0] seq_bits;
  logic [15:0] seq_mask;

  fsm_101_0110 dut (.clk(clk), .reset(reset), .din(din), .y(y));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic model_y();
    return (nbits >= 3 && hist[2:0] == 3'b101) || (nbits >= 4 && hist == 4'b0110);
  endfunction

  task automatic step(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
    hist = {hist[2:0], b};
    nbits++;
    chk("y_model", {3'b0, y}, {3'b0, model_y()});
  endtask

  task automatic do_reset(input int cycles);
    #1 reset = 1'b0;
    #1;
    hist = 4'b0;
    nbits = 0;
    chk("rst_async_y", {3'b0, y}, 4'd0);
    chk("rst_async_cst", {1'b0, dut.cst}, 4'd0);
    repeat (cycles) begin
      @(negedge clk);
      din = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_hold_y", {3'b0, y}, 4'd0);
      chk("rst_hold_cst", {1'b0, dut.cst}, 4'd0);
    end
    reset = 1'b1;
  endtask

  task automatic run_seq(input string tag, input logic [15:0] bits, input logic [15:0] mask, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      step(bits[i]);
      chk(tag, {3'b0, y}, {3'b0, mask[i]});
    end
  endtask

  initial begin
    reset = 1'b1;
    din = 1'b0;
    hist = 4'b0;
    nbits = 0;
    #1;
    do_reset(3);
    seq_bits = 16'b0000_0000_0000_0110;
    seq_mask = 16'b0000_0000_0000_0001;
    run_seq("basic_0110", seq_bits, seq_mask, 5);
    chk("basic_cst", {1'b0, dut.cst}, 4'd7);
    do_reset(3);
    seq_bits = 16'b0011_0110_0101_0110;
    seq_mask = 16'b0000_1101_0001_0101;
    run_seq("chained", seq_bits, seq_mask, 16);
    do_reset(1);
    seq_bits = 16'b0000_0001_1100_0111;
    seq_mask = 16'b0;
    run_seq("nonmatch", seq_bits, seq_mask, 9);
    chk("nonmatch_cst", {1'b0, dut.cst}, 4'd2);
    do_reset(1);
    step(1'b1);
    step(1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_y", {3'b0, y}, 4'd0);
    chk("mid_rst_cst", {1'b0, dut.cst}, 4'd0);
    hist = 4'b0;
    nbits = 0;
    #2 reset = 1'b1;
    step(1'b1);
    chk("mid_after_y", {3'b0, y}, 4'd0);
    chk("mid_after_cst", {1'b0, dut.cst}, 4'd2);
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      step(1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
